// File: rtl/octane_pkg.sv
// Shared types and default sizes for the audio mixing path.
package octane_pkg;

   localparam int DEF_NUM_VOICES   = 8;
   localparam int DEF_SAMPLE_WIDTH = 24;

   typedef logic signed [DEF_SAMPLE_WIDTH-1:0] Sample_t;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      FINISH
   } MixerState_t;

endpackage

// File: rtl/sample_limit.sv
// Reduces the full-precision voice sum to an output sample.
// VOICE_MIXER_SATURATE_EN selects clipping at unity gain; otherwise divide by the voice count.
module sample_limit #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int SEL_WIDTH    = 3,
   parameter int ACC_WIDTH    = SAMPLE_WIDTH + SEL_WIDTH
) (
   input  logic signed [ACC_WIDTH-1:0]    acc,
   output logic signed [SAMPLE_WIDTH-1:0] sample
);

`ifdef VOICE_MIXER_SATURATE_EN
   // In range exactly when every bit above the output sign bit matches the accumulator sign.
   logic [SEL_WIDTH:0] upper;
   logic               in_range;

   assign upper    = acc[ACC_WIDTH-1:SAMPLE_WIDTH-1];
   assign in_range = (upper == {(SEL_WIDTH+1){acc[ACC_WIDTH-1]}});

   always_comb begin
      sample = acc[SAMPLE_WIDTH-1:0];
      if (!in_range) begin
         sample = acc[ACC_WIDTH-1] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}
                                   : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
      end
   end
`else
   // Arithmetic shift by SEL_WIDTH; the top bits of the exact sum are the result.
   assign sample = acc[ACC_WIDTH-1:SEL_WIDTH];
`endif

endmodule

// File: rtl/voice_mixer.sv
// Scans all voices once per sample tick, sums unmuted samples and presents the mix downstream.
// Output scaling comes from sample_limit (VOICE_MIXER_SATURATE_EN: clip, else 1/NUM_VOICES gain).
module voice_mixer
   import octane_pkg::*;
#(
   parameter  int NUM_VOICES   = DEF_NUM_VOICES,
   parameter  int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
   localparam int SEL_WIDTH    = $clog2(NUM_VOICES),
   localparam int ACC_WIDTH    = SAMPLE_WIDTH + SEL_WIDTH
) (
   input  logic                           i_Clock,
   input  logic                           i_Reset,
   input  logic                           i_SampleTick,
   output logic [SEL_WIDTH-1:0]           o_VoiceSelect,
   input  logic signed [SAMPLE_WIDTH-1:0] i_VoiceSample,
   input  logic [NUM_VOICES-1:0]          i_VoiceMute,
   output logic signed [SAMPLE_WIDTH-1:0] o_Sample,
   output logic                           o_Valid,
   input  logic                           i_Ready,
   output logic                           o_Busy,
   output logic                           o_Overrun
);

   localparam int CNT_WIDTH = SEL_WIDTH + 1;

   // Handshake: a result moves downstream in any cycle where o_Valid && i_Ready;
   // o_Sample is held while o_Valid is high unless FINISH overwrites it.

   MixerState_t                   state;
   logic [SEL_WIDTH-1:0]          idx;
   logic [CNT_WIDTH-1:0]          cnt;
   logic signed [ACC_WIDTH-1:0]   acc;
   logic signed [ACC_WIDTH-1:0]   voice_ext;
   logic [SEL_WIDTH-1:0]          acc_idx;
   logic signed [SAMPLE_WIDTH-1:0] limited;

   // The sample arriving now belongs to the voice selected one cycle earlier.
   assign acc_idx   = idx - SEL_WIDTH'(1);
   assign voice_ext = {{SEL_WIDTH{i_VoiceSample[SAMPLE_WIDTH-1]}}, i_VoiceSample};

   assign o_VoiceSelect = idx;
   assign o_Busy        = (state != IDLE);

   sample_limit #(
      .SAMPLE_WIDTH(SAMPLE_WIDTH),
      .SEL_WIDTH   (SEL_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH)
   ) u_limit (
      .acc   (acc),
      .sample(limited)
   );

   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         state     <= IDLE;
         idx       <= '0;
         cnt       <= '0;
         acc       <= '0;
         o_Sample  <= '0;
         o_Valid   <= 1'b0;
         o_Overrun <= 1'b0;
      end else begin
         o_Overrun <= 1'b0;
         if (o_Valid && i_Ready) begin
            o_Valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (i_SampleTick) begin
                  state <= SCAN;
                  acc   <= '0;
                  idx   <= '0;
                  cnt   <= '0;
               end
            end
            SCAN: begin
               idx <= idx + SEL_WIDTH'(1);
               cnt <= cnt + CNT_WIDTH'(1);
               // First SCAN cycle only fills the mux pipeline.
               if (cnt != '0 && !i_VoiceMute[acc_idx]) begin
                  acc <= acc + voice_ext;
               end
               if (cnt == CNT_WIDTH'(NUM_VOICES)) begin
                  state <= FINISH;
               end
               if (i_SampleTick) begin
                  o_Overrun <= 1'b1;
               end
            end
            FINISH: begin
               o_Sample <= limited;
               o_Valid  <= 1'b1;
               idx      <= '0;
               state    <= IDLE;
               if ((o_Valid && !i_Ready) || i_SampleTick) begin
                  o_Overrun <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer with 8 voices; expected mixes follow VOICE_MIXER_SATURATE_EN.
module tb_voice_mixer;
   import octane_pkg::*;

   localparam int NV = 8;
   localparam int SW = 24;

`ifdef VOICE_MIXER_SATURATE_EN
   localparam logic [SW-1:0] EXP_BASIC = 24'd36000;
   localparam logic [SW-1:0] EXP_MUTE  = 24'd27000;
`else
   localparam logic [SW-1:0] EXP_BASIC = 24'd4500;
   localparam logic [SW-1:0] EXP_MUTE  = 24'd3375;
`endif
   localparam logic [SW-1:0] EXP_POS_CLIP = 24'h7FFFFF;
   localparam logic [SW-1:0] EXP_NEG_CLIP = 24'h800000;

   logic          i_Clock      = 1'b0;
   logic          i_Reset      = 1'b0;
   logic          i_SampleTick = 1'b0;
   logic          i_Ready      = 1'b0;
   logic [NV-1:0] i_VoiceMute  = '0;
   logic [2:0]    o_VoiceSelect;
   Sample_t       i_VoiceSample;
   logic [SW-1:0] o_Sample;
   logic          o_Valid;
   logic          o_Busy;
   logic          o_Overrun;

   Sample_t       voices [NV];

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int ovr_cnt  = 0;
   int xfer_cnt = 0;
   logic [SW-1:0] exp_q[$];

   voice_mixer #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW)) dut (
      .i_Clock      (i_Clock),
      .i_Reset      (i_Reset),
      .i_SampleTick (i_SampleTick),
      .o_VoiceSelect(o_VoiceSelect),
      .i_VoiceSample(i_VoiceSample),
      .i_VoiceMute  (i_VoiceMute),
      .o_Sample     (o_Sample),
      .o_Valid      (o_Valid),
      .i_Ready      (i_Ready),
      .o_Busy       (o_Busy),
      .o_Overrun    (o_Overrun)
   );

   // clock / voice array model
   always #5 i_Clock = ~i_Clock;

   always @(posedge i_Clock) i_VoiceSample <= voices[o_VoiceSelect];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // monitor: samples late in the cycle, just before the edge that performs the transfer
   always @(negedge i_Clock) begin
      #3;
      if (i_Reset) begin
         if (o_Overrun) ovr_cnt++;
         if (o_Valid && i_Ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
               chk_cnt++;
               $display("FAIL unexpected_xfer: got sample 0x%0h expected no transfer", o_Sample);
            end else begin
               check("sample", {40'd0, o_Sample}, {40'd0, exp_q.pop_front()});
            end
         end
      end
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) @(negedge i_Clock);
      #1;
   endtask

   task automatic tick_pulse();
      step(1);
      i_SampleTick = 1'b1;
      step(1);
      i_SampleTick = 1'b0;
   endtask

   task automatic set_basic();
      for (int k = 0; k < NV; k++) voices[k] = Sample_t'(1000 * (k + 1));
   endtask

   task automatic set_all(input Sample_t v);
      for (int k = 0; k < NV; k++) voices[k] = v;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},   o_Valid, 0);
      check({tag, "_busy"},    o_Busy, 0);
      check({tag, "_overrun"}, o_Overrun, 0);
      check({tag, "_sample"},  o_Sample, 0);
      check({tag, "_select"},  o_VoiceSelect, 0);
   endtask

   int ovr0, xfer0;

   initial begin
      set_basic();
      step(3);
      check_all_zero("reset");
      i_Reset = 1'b1;
      step(2);

      // basic mix and latency: tick in cycle 0, o_Valid from cycle 11
      i_Ready = 1'b1;
      exp_q.push_back(EXP_BASIC);
      tick_pulse();
      step(2);
      check("scan_select", o_VoiceSelect, 2);
      check("scan_busy", o_Busy, 1);
      step(7);
      check("lat_early_valid", o_Valid, 0);
      check("finish_busy", o_Busy, 1);
      step(1);
      check("lat_valid", o_Valid, 1);
      check("idle_select", o_VoiceSelect, 0);
      step(1);
      check("valid_drop", o_Valid, 0);
      check("idle_busy", o_Busy, 0);
      step(3);

      // full-scale positive and negative sums
      set_all(Sample_t'(24'h7FFFFF));
      exp_q.push_back(EXP_POS_CLIP);
      tick_pulse();
      step(14);
      set_all(Sample_t'(24'h800000));
      exp_q.push_back(EXP_NEG_CLIP);
      tick_pulse();
      step(14);

      // voices 0 and 7 muted
      set_basic();
      i_VoiceMute = 8'b1000_0001;
      exp_q.push_back(EXP_MUTE);
      tick_pulse();
      step(14);
      i_VoiceMute = '0;

      // backpressure: second result overwrites the unconsumed first one
      i_Ready = 1'b0;
      ovr0 = ovr_cnt;
      tick_pulse();
      step(14);
      check("bp_hold_valid", o_Valid, 1);
      check("bp_first_sample", o_Sample, EXP_BASIC);
      i_VoiceMute = 8'b1000_0001;
      exp_q.push_back(EXP_MUTE);
      tick_pulse();
      step(14);
      i_VoiceMute = '0;
      check("bp_overrun_count", ovr_cnt - ovr0, 1);
      check("bp_still_valid", o_Valid, 1);
      xfer0 = xfer_cnt;
      i_Ready = 1'b1;
      step(1);
      check("bp_valid_drop", o_Valid, 0);
      step(3);
      check("bp_xfer_count", xfer_cnt - xfer0, 1);

      // tick while busy: dropped with an overrun pulse, one result only
      ovr0  = ovr_cnt;
      xfer0 = xfer_cnt;
      exp_q.push_back(EXP_BASIC);
      tick_pulse();
      step(3);
      i_SampleTick = 1'b1;
      check("busy_ovr_before", o_Overrun, 0);
      step(1);
      i_SampleTick = 1'b0;
      check("busy_ovr_pulse", o_Overrun, 1);
      step(10);
      check("busy_xfer_count", xfer_cnt - xfer0, 1);
      step(10);
      check("busy_no_second_mix", xfer_cnt - xfer0, 1);
      check("busy_overrun_count", ovr_cnt - ovr0, 1);
      check("busy_idle", o_Busy, 0);

      // reset mid-scan while a result is held
      i_Ready = 1'b0;
      tick_pulse();
      step(14);
      check("rst_pre_valid", o_Valid, 1);
      tick_pulse();
      step(3);
      check("rst_pre_busy", o_Busy, 1);
      i_Reset = 1'b0;
      #1;
      check_all_zero("midscan_reset");
      exp_q.delete();
      step(2);
      i_Reset = 1'b1;
      xfer0 = xfer_cnt;
      i_Ready = 1'b1;
      step(20);
      check("post_reset_no_xfer", xfer_cnt - xfer0, 0);
      check("post_reset_valid", o_Valid, 0);

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
